burst_ram_masked: RTL and testbench

Next-generation simulation model of the external burst RAM IP, used in benches in place of the vendor component. It honours the byte mask on writes, wraps burst addresses modulo depth, and flags commands issued while busy. It also emulates periodic refresh stalls, so controller timing is exercised the way the real part exercises it. It sits between the cache/memory controller under test and nothing: the block is a leaf.

---
 rtl/burst_ram_masked_if.sv | 25 ++
 rtl/burst_ram_masked.sv | 170 +++++++++++++++++
 tb/tb_burst_ram_masked.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_ram_masked_if.sv
// Command/data bus between a memory controller (master) and the burst RAM model (slave).
interface burst_ram_masked_if #(
  parameter int unsigned DEPTH_BITWIDTH = 4,
  parameter int unsigned DATA_BITWIDTH  = 64
);
  logic                         cmd;
  logic                         cmd_en;
  logic [DEPTH_BITWIDTH-1:0]    addr;
  logic [DATA_BITWIDTH-1:0]     wr_data;
  logic [DATA_BITWIDTH/8-1:0]   data_mask;
  logic [DATA_BITWIDTH-1:0]     rd_data;
  logic                         rd_data_valid;
  logic                         busy;
  logic                         cmd_dropped;

  modport master (
    output cmd, cmd_en, addr, wr_data, data_mask,
    input  rd_data, rd_data_valid, busy, cmd_dropped
  );

  modport slave (
    input  cmd, cmd_en, addr, wr_data, data_mask,
    output rd_data, rd_data_valid, busy, cmd_dropped
  );
endinterface

// File: rtl/burst_ram_masked.sv
// Burst RAM model: byte-masked write bursts, delayed read bursts with wrapping
// addresses, busy/drop signalling and optional periodic refresh stalls.
module burst_ram_masked #(
  parameter int unsigned DEPTH_BITWIDTH   = 4,
  parameter string       DATA_FILE        = "",
  parameter int unsigned READ_LATENCY     = 8,
  parameter int unsigned BURST_COUNT      = 4,
  parameter int unsigned DATA_BITWIDTH    = 64,
  parameter int unsigned REFRESH_INTERVAL = 0,
  parameter int unsigned REFRESH_CYCLES   = 4
) (
  input  logic               clk,
  input  logic               rst,
  burst_ram_masked_if.slave  bus
);

  localparam int unsigned DEPTH   = 1 << DEPTH_BITWIDTH;
  localparam int unsigned MASK_W  = DATA_BITWIDTH / 8;
  localparam int unsigned MAX_LB  = (READ_LATENCY > BURST_COUNT) ? READ_LATENCY : BURST_COUNT;
  localparam int unsigned CNT_MAX = (MAX_LB > REFRESH_CYCLES) ? MAX_LB : REFRESH_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned TMR_W   = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_DELAY,
    READ_BURST,
    WRITE_BURST,
    REFRESH
  } state_t;

  logic [DATA_BITWIDTH-1:0]  mem [DEPTH];

  state_t                    state, state_d;
  logic [CNT_W-1:0]          cnt, cnt_d;
  logic [DEPTH_BITWIDTH-1:0] ptr, ptr_d;
  logic [DATA_BITWIDTH-1:0]  rd_data_q, rd_data_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic                      dropped_q, dropped_d;
  logic [TMR_W-1:0]          timer, timer_d;
  logic                      pending, pending_d;

  logic                      expire;
  logic                      refresh_start;
  logic                      accept;
  logic                      we;
  logic [DEPTH_BITWIDTH-1:0] waddr;

  always_comb begin
    expire  = (REFRESH_INTERVAL != 0) && (timer == TMR_W'(REFRESH_INTERVAL - 1));
    timer_d = timer;
    if (expire)                     timer_d = '0;
    else if (REFRESH_INTERVAL != 0) timer_d = timer + TMR_W'(1);
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    ptr_d     = ptr;
    rd_data_d = rd_data_q;
    valid_d   = valid_q;
    we        = 1'b0;
    waddr     = ptr;

    // A pending refresh wins the IDLE edge; any command on that edge is lost.
    refresh_start = (state == IDLE) && pending;
    accept        = (state == IDLE) && !pending && bus.cmd_en;
    dropped_d     = bus.cmd_en && !accept;
    pending_d     = expire || (pending && !refresh_start);

    case (state)
      IDLE: begin
        if (refresh_start) begin
          state_d = REFRESH;
          cnt_d   = '0;
        end else if (accept) begin
          if (bus.cmd) begin
            we      = 1'b1;
            waddr   = bus.addr;
            ptr_d   = bus.addr + DEPTH_BITWIDTH'(1);
            cnt_d   = CNT_W'(1);
            state_d = WRITE_BURST;
          end else begin
            ptr_d   = bus.addr;
            cnt_d   = '0;
            state_d = READ_DELAY;
          end
        end
      end
      READ_DELAY: begin
        if (cnt == CNT_W'(READ_LATENCY)) begin
          rd_data_d = mem[ptr];
          valid_d   = 1'b1;
          ptr_d     = ptr + DEPTH_BITWIDTH'(1);
          cnt_d     = CNT_W'(1);
          state_d   = READ_BURST;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      READ_BURST: begin
        if (cnt == CNT_W'(BURST_COUNT)) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          rd_data_d = mem[ptr];
          ptr_d     = ptr + DEPTH_BITWIDTH'(1);
          cnt_d     = cnt + CNT_W'(1);
        end
      end
      WRITE_BURST: begin
        // The cycle after the last beat is still busy before returning to IDLE.
        if (cnt == CNT_W'(BURST_COUNT)) begin
          state_d = IDLE;
        end else begin
          we    = 1'b1;
          ptr_d = ptr + DEPTH_BITWIDTH'(1);
          cnt_d = cnt + CNT_W'(1);
        end
      end
      REFRESH: begin
        if (cnt == CNT_W'(REFRESH_CYCLES - 1)) state_d = IDLE;
        else                                  cnt_d   = cnt + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      rd_data_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
      timer     <= '0;
      pending   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      ptr       <= ptr_d;
      rd_data_q <= rd_data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
      timer     <= timer_d;
      pending   <= pending_d;
    end
  end

  // Contents survive reset; reset only blocks writes while it is held.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      for (int unsigned i = 0; i < MASK_W; i++) begin
        if (!bus.data_mask[i]) mem[waddr][8*i +: 8] <= bus.wr_data[8*i +: 8];
      end
    end
  end

  assign bus.rd_data       = rd_data_q;
  assign bus.rd_data_valid = valid_q;
  assign bus.busy          = busy_q;
  assign bus.cmd_dropped   = dropped_q;

endmodule

// File: tb/tb_burst_ram_masked.sv
// Scoreboarded bench for burst_ram_masked: a no-refresh instance under directed and
// random traffic, and a refresh-enabled instance checked cycle by cycle.
module tb_burst_ram_masked;

  localparam int AW = 4;
  localparam int DW = 64;
  localparam int DEPTH = 16;
  localparam int BC = 4;
  localparam int RL = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  burst_ram_masked_if #(.DEPTH_BITWIDTH(AW), .DATA_BITWIDTH(DW)) bus_a ();
  burst_ram_masked_if #(.DEPTH_BITWIDTH(AW), .DATA_BITWIDTH(DW)) bus_b ();

  burst_ram_masked #(
    .DEPTH_BITWIDTH(AW), .DATA_FILE(""), .READ_LATENCY(RL), .BURST_COUNT(BC),
    .DATA_BITWIDTH(DW), .REFRESH_INTERVAL(0), .REFRESH_CYCLES(4)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  burst_ram_masked #(
    .DEPTH_BITWIDTH(AW), .DATA_FILE(""), .READ_LATENCY(RL), .BURST_COUNT(BC),
    .DATA_BITWIDTH(DW), .REFRESH_INTERVAL(20), .REFRESH_CYCLES(4)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Edge counter since reset release: value n is sampled after the n-th rising edge.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct { logic [63:0] data; int cyc; } beat_t;
  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] model [DEPTH];
  logic [63:0] beat_d [BC];
  logic [7:0]  beat_m [BC];

  function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                        input logic [7:0] m);
    logic [63:0] keep = '0;
    for (int i = 0; i < 8; i++) if (m[i]) keep = keep | (64'hFF << (8 * i));
    return (old_w & keep) | (new_w & ~keep);
  endfunction

  function automatic bit in_win(input int n, input int s, input int len);
    return (n >= s) && (n < s + len);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic run_monitor();
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus_a.rd_data_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h at cycle %0d required no beat", bus_a.rd_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", bus_a.rd_data, e.data);
          check("beat_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus_a.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 64'(bus_a.busy), 64'(0));
  endtask

  task automatic do_write(input logic [3:0] a, input bit rand_en);
    logic [3:0] idx;
    wait_idle();
    for (int k = 0; k < BC; k++) begin
      bus_a.cmd       = 1'b1;
      bus_a.cmd_en    = (k == 0) ? 1'b1 : (rand_en ? 1'($urandom_range(0, 1)) : 1'b0);
      bus_a.addr      = (k == 0) ? a : 4'($urandom);
      bus_a.wr_data   = beat_d[k];
      bus_a.data_mask = beat_m[k];
      @(negedge clk);
      idx = a + 4'(k);
      model[idx] = merge(model[idx], beat_d[k], beat_m[k]);
    end
    bus_a.cmd_en = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, output int c0);
    logic [3:0] idx;
    wait_idle();
    bus_a.cmd    = 1'b0;
    bus_a.cmd_en = 1'b1;
    bus_a.addr   = a;
    @(negedge clk);
    bus_a.cmd_en = 1'b0;
    c0 = cyc;
    for (int k = 0; k < BC; k++) begin
      idx = a + 4'(k);
      exp_q.push_back('{data: model[idx], cyc: c0 + RL + 1 + k});
    end
    check("accept_busy", 64'(bus_a.busy), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int c0;
    int r;
    bit busy_exp, valid_exp, drop_exp;

    bus_a.cmd = 1'b0; bus_a.cmd_en = 1'b0; bus_a.addr = '0; bus_a.wr_data = '0; bus_a.data_mask = '0;
    bus_b.cmd = 1'b0; bus_b.cmd_en = 1'b0; bus_b.addr = '0; bus_b.wr_data = '0; bus_b.data_mask = '0;
    fork run_monitor(); join_none

    repeat (2) @(negedge clk);
    check("rst_rd_data", bus_a.rd_data, 64'd0);
    check("rst_valid", 64'(bus_a.rd_data_valid), 64'(0));
    check("rst_busy", 64'(bus_a.busy), 64'(0));
    check("rst_dropped", 64'(bus_a.cmd_dropped), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 64'(bus_a.busy), 64'(0));
    check("post_rst_busy_b", 64'(bus_b.busy), 64'(0));

    // Preload mem[i] = i.
    for (int j = 0; j < DEPTH / BC; j++) begin
      for (int k = 0; k < BC; k++) begin
        beat_d[k] = 64'(BC * j + k);
        beat_m[k] = 8'h00;
      end
      do_write(4'(BC * j), 1'b0);
    end

    // Read at 2: first beat after edge 9, busy drops after edge 13.
    do_read(4'd2, c0);
    repeat (12) @(negedge clk);
    check("busy_edge12", 64'(bus_a.busy), 64'(1));
    @(negedge clk);
    check("busy_edge13", 64'(bus_a.busy), 64'(0));
    check("valid_edge13", 64'(bus_a.rd_data_valid), 64'(0));
    check("rd_data_hold", bus_a.rd_data, 64'd5);

    // Wrapping write at 14 and readback.
    for (int k = 0; k < BC; k++) begin
      beat_d[k] = 64'hA0 + 64'(k);
      beat_m[k] = 8'h00;
    end
    do_write(4'd14, 1'b0);
    do_read(4'd14, c0);

    // Byte mask behaviour at word 4.
    beat_d[0] = 64'h1111_2222_3333_4444; beat_m[0] = 8'h00;
    for (int k = 1; k < BC; k++) begin
      beat_d[k] = {$urandom, $urandom};
      beat_m[k] = 8'hFF;
    end
    do_write(4'd4, 1'b0);
    beat_d[0] = 64'hFFFF_FFFF_FFFF_FFFF; beat_m[0] = 8'h0F;
    beat_d[1] = {$urandom, $urandom};    beat_m[1] = 8'hFF;
    beat_d[2] = {$urandom, $urandom};    beat_m[2] = 8'($urandom);
    beat_d[3] = {$urandom, $urandom};    beat_m[3] = 8'h00;
    do_write(4'd4, 1'b0);
    do_read(4'd4, c0);
    exp_q[exp_q.size() - BC].data = 64'hFFFF_FFFF_3333_4444;

    // Commands issued during a read burst must be dropped without side effects.
    do_read(4'd0, c0);
    repeat (4) @(negedge clk);
    bus_a.cmd = 1'b1; bus_a.cmd_en = 1'b1; bus_a.addr = 4'd0;
    bus_a.wr_data = {$urandom, $urandom}; bus_a.data_mask = 8'h00;
    @(negedge clk);
    bus_a.cmd_en = 1'b0;
    check("drop_delay", 64'(bus_a.cmd_dropped), 64'(1));
    check("drop_busy", 64'(bus_a.busy), 64'(1));
    @(negedge clk);
    check("drop_pulse_end", 64'(bus_a.cmd_dropped), 64'(0));
    repeat (3) @(negedge clk);
    bus_a.cmd = 1'b0; bus_a.cmd_en = 1'b1; bus_a.addr = 4'd7;
    @(negedge clk);
    bus_a.cmd_en = 1'b0;
    check("drop_in_burst", 64'(bus_a.cmd_dropped), 64'(1));
    wait_idle();
    repeat (15) @(negedge clk);

    // Random traffic against the array model.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < BC; k++) begin
          beat_d[k] = {$urandom, $urandom};
          r = int'($urandom_range(0, 3));
          beat_m[k] = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
        end
        do_write(4'($urandom), 1'b1);
      end else begin
        do_read(4'($urandom), c0);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int j = 0; j < DEPTH / BC; j++) do_read(4'(BC * j), c0);

    // Reset during write beat 2: beats 0..1 land, 2..3 do not.
    wait_idle();
    for (int k = 0; k < BC; k++) begin
      beat_d[k] = 64'hC0C0_0000_0000_0000 + 64'(k);
      beat_m[k] = 8'h00;
    end
    for (int k = 0; k < 2; k++) begin
      bus_a.cmd = 1'b1; bus_a.cmd_en = (k == 0); bus_a.addr = 4'd8;
      bus_a.wr_data = beat_d[k]; bus_a.data_mask = 8'h00;
      @(negedge clk);
      model[8 + k] = beat_d[k];
    end
    bus_a.cmd_en = 1'b0; bus_a.wr_data = beat_d[2];
    rst = 1'b1;
    #1;
    check("midrst_rd_data", bus_a.rd_data, 64'd0);
    check("midrst_valid", 64'(bus_a.rd_data_valid), 64'(0));
    check("midrst_busy", 64'(bus_a.busy), 64'(0));
    check("midrst_dropped", 64'(bus_a.cmd_dropped), 64'(0));
    bus_a.wr_data = beat_d[3];
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_release_busy", 64'(bus_a.busy), 64'(0));
    do_read(4'd8, c0);
    wait_idle();
    r = 0;
    while (exp_q.size() != 0 && r < 50) begin
      @(negedge clk);
      r++;
    end
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    // Refresh instance from a fresh reset. Expiries fall on edges 20,40,..; each refresh
    // starts at the next IDLE edge and holds busy 4 cycles. cmd_en at edge 61 collides
    // with a refresh start; edge 66 is the first busy=0 edge; the read at 90 spans the
    // expiry at 100, so that refresh waits until edge 104.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 130; n++) begin
      bus_b.cmd    = 1'b0;
      bus_b.addr   = 4'($urandom);
      bus_b.cmd_en = (n == 61) || (n == 66) || (n == 90);
      @(negedge clk);
      busy_exp  = in_win(n, 21, 4) || in_win(n, 41, 4) || in_win(n, 61, 4) ||
                  in_win(n, 81, 4) || in_win(n, 104, 4) || in_win(n, 121, 4) ||
                  in_win(n, 66, RL + 1 + BC) || in_win(n, 90, RL + 1 + BC);
      valid_exp = in_win(n, 66 + RL + 1, BC) || in_win(n, 90 + RL + 1, BC);
      drop_exp  = (n == 61);
      check("refresh_busy", 64'(bus_b.busy), 64'(busy_exp));
      check("refresh_valid", 64'(bus_b.rd_data_valid), 64'(valid_exp));
      check("refresh_dropped", 64'(bus_b.cmd_dropped), 64'(drop_exp));
    end
    bus_b.cmd_en = 1'b0;
    check("refresh_edge_count", 64'(cyc), 64'(130));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
